button_stepper: RTL and testbench
=================================

// Module: button_stepper
// PURPOSE
//  Front-end conditioner for the board push-button feeding the LED rotator.
//  Synchronises and debounces the raw pad, then issues one-cycle active-low step
//  strobes: one on press, then auto-repeat while the button is held.
//  Output step_n plugs directly into the rotator's active-low btn input
//  (one rotation per strobe, not one per clock).
// PARAMETERS
//  DEBOUNCE_CYCLES  50_000      consecutive stable samples needed to accept a level change
//  REPEAT_DELAY     25_000_000  cycles from first step to first auto-repeat step
//  REPEAT_PERIOD    5_000_000   cycles between auto-repeat steps
//  CNT_W            25          shared counter width; must hold max(params)-1 (elab-time assert)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high
//  btn_raw_n  in   1  raw pad, active-low (0 = pressed), asynchronous to clk
//  step_n     out  1  active-low step strobe, exactly one clk low per step
//  pressed    out  1  debounced button level, 1 = held
//  repeating  out  1  1 while in auto-repeat phase
// BEHAVIOUR
//  Reset (async, active-high): state IDLE, cnt=0, sync flops=1 (released),
//   step_n=1, pressed=0, repeating=0. Every output is a flop; no combinational paths.
//  Sync: 2-flop synchroniser on btn_raw_n; s = ~sync_out (1 = pressed).
//  FSM; cnt is cleared on every state change:
//   IDLE        s=1 -> DEB_PRESS.
//   DEB_PRESS   s=0 -> IDLE, no step. Else cnt++.
//               cnt==DEBOUNCE_CYCLES-1 -> HELD, step_n=0 for one cycle, pressed=1.
//   HELD        s=0 -> DEB_RELEASE. Else cnt++.
//               cnt==REPEAT_DELAY-1 -> REPEAT, step, repeating=1.
//   REPEAT      s=0 -> DEB_RELEASE. Else cnt++.
//               cnt==REPEAT_PERIOD-1 -> step, cnt=0, stay.
//   DEB_RELEASE s=1 (bounce) -> HELD, no step, repeating=0; the repeat delay restarts.
//               Else cnt++. cnt==DEBOUNCE_CYCLES-1 -> IDLE, pressed=0, repeating=0.
//  Latency: if raw low is first sampled at edge E0, step_n goes low after edge
//   E0+DEBOUNCE_CYCLES+2. First repeat comes REPEAT_DELAY edges later,
//   then one step every REPEAT_PERIOD edges.
//  step_n never stays low for 2 consecutive cycles, including when
//   REPEAT_PERIOD=1 (minimum legal value is 2).
//  Glitch shorter than DEBOUNCE_CYCLES in IDLE: no step, pressed stays 0.
//  Reset mid-press: immediate return to reset values. After release of reset,
//   a still-held button is treated as a new press (full debounce, then step).
//  cnt saturates by construction (compare-and-clear); no wrap-around is possible.
// STRUCTURE
//  btn_pkg: state enum (IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE), 3-bit encoding;
//   CNT_W default constant.
//  Sub-module sync2: generic 2-flop synchroniser with RESET_VAL parameter (=1 here);
//   reused for other pad inputs.
//  Top: FSM + single shared cnt + registered outputs.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Clean press at E0, held 12 edges, then released -> exactly one step_n low,
//     after edge E0+6; pressed=1 from the same edge; no repeat.
//  2. Held 40 edges -> steps after edges E0+6, +16, +19, +22, ...;
//     repeating=1 from E0+16; every strobe is 1 cycle wide.
//  3. Raw pulses low for 3 edges, 3 times, in IDLE -> zero steps; pressed stays 0.
//  4. Held, then release with a 2-edge bounce back to pressed -> returns to HELD,
//     no extra step, pressed stays 1; a clean release then gives pressed=0
//     4 edges after s=0 is held stable.
//  5. Assert reset mid-REPEAT while btn is held -> step_n=1, pressed=0, repeating=0
//     asynchronously; after deassert, the first step comes 6 edges after the first sample.
//  6. Integration: button_stepper drives the rotator from reset value 8'h01 through
//     9 steps -> lights = 8'h02 after the 1st step, 8'h01 after the 8th (wrap),
//     8'h02 after the 9th.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning blocks.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  localparam int CNT_W_DEFAULT = 25;

  // Widest terminal count among the timing parameters; the shared counter must hold it minus one.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous pad inputs; RESET_VAL is the idle pad level.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_stepper.sv
// Synchronises and debounces an active-low push-button, then emits one-cycle active-low step strobes
// on press and auto-repeats while held. All outputs are registered.
module button_stepper
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_n,
  output logic step_n,
  output logic pressed,
  output logic repeating
);

  localparam int MAX_CYCLES = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  if ((longint'(MAX_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_too_narrow
    $error("button_stepper: CNT_W too small for the largest timing parameter");
  end
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_timing
    $error("button_stepper: timing parameters out of range");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic btn_sync_n;
  logic s;

  sync2 #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw_n),
    .q    (btn_sync_n)
  );

  assign s = ~btn_sync_n;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             step_req;
  logic             pressed_nxt;
  logic             repeating_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step_n    <= 1'b1;
      pressed   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // A strobe directly after another is swallowed so step_n is never low twice in a row.
      step_n    <= ~(step_req & step_n);
      pressed   <= pressed_nxt;
      repeating <= repeating_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CNT_W'(1);
    step_req      = 1'b0;
    pressed_nxt   = pressed;
    repeating_nxt = repeating;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        pressed_nxt   = 1'b0;
        repeating_nxt = 1'b0;
        if (s) begin
          state_nxt = DEB_PRESS;
        end
      end

      DEB_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = HELD;
          cnt_nxt     = '0;
          step_req    = 1'b1;
          pressed_nxt = 1'b1;
        end
      end

      HELD: begin
        if (!s) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == DLY_LAST) begin
          state_nxt     = REPEAT;
          cnt_nxt       = '0;
          step_req      = 1'b1;
          repeating_nxt = 1'b1;
        end
      end

      REPEAT: begin
        if (!s) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == PER_LAST) begin
          cnt_nxt  = '0;
          step_req = 1'b1;
        end
      end

      DEB_RELEASE: begin
        if (s) begin
          // Bounce back to pressed: full repeat delay starts over from HELD.
          state_nxt     = HELD;
          cnt_nxt       = '0;
          repeating_nxt = 1'b0;
        end else if (cnt == DEB_LAST) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          pressed_nxt   = 1'b0;
          repeating_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_stepper.sv
// Drives button_stepper with directed and random press patterns; compares against a run-length reference model.
module tb_button_stepper;

  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 3;

  logic clk;
  logic reset;
  logic btn_raw_n;
  logic step_n;
  logic pressed;
  logic repeating;
  logic [7:0] lights;

  int checks = 0;
  int errors = 0;

  button_stepper #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (R),
    .REPEAT_PERIOD  (P),
    .CNT_W          (25)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw_n(btn_raw_n),
    .step_n   (step_n),
    .pressed  (pressed),
    .repeating(repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream LED rotator: one left rotation per active-low strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) lights <= 8'h01;
    else if (step_n == 1'b0) lights <= {lights[6:0], lights[7]};
  end

  // Reference model: raw samples reach the decision logic two edges late; a level change is
  // accepted after D+1 consecutive disagreeing edges; steps at acceptance, then R, R+P, R+2P...
  // edges after the most recent (re)entry into the held phase.
  logic m_hist[$];
  bit   m_level;
  bit   m_rep;
  int   m_run;
  int   m_th;

  int edge_no;
  int step_q[$];
  int first_press;
  int rep_edge;

  task automatic model_reset();
    m_hist  = {1'b1, 1'b1};
    m_level = 0;
    m_rep   = 0;
    m_run   = 0;
    m_th    = 0;
  endtask

  task automatic model_edge(input logic raw, output bit step);
    bit s;
    int age;
    s = ~m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(raw);
    step = 0;
    if (!m_level) begin
      if (s) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = 1;
          m_run   = 0;
          m_th    = edge_no;
          step    = 1;
        end
      end else begin
        m_run = 0;
      end
    end else if (!s) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = 0;
        m_rep   = 0;
        m_run   = 0;
      end
    end else if (m_run > 0) begin
      m_run = 0;
      m_th  = edge_no;
      m_rep = 0;
    end else begin
      age = edge_no - m_th;
      if (age >= R && (age - R) % P == 0) begin
        step  = 1;
        m_rep = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic cyc(input logic raw);
    bit st;
    btn_raw_n = raw;
    @(posedge clk);
    edge_no++;
    model_edge(raw, st);
    #1;
    chk("step_n", {31'd0, step_n}, {31'd0, ~st});
    chk("pressed", {31'd0, pressed}, {31'd0, m_level});
    chk("repeating", {31'd0, repeating}, {31'd0, m_rep});
    if (step_n === 1'b0) step_q.push_back(edge_no);
    if (pressed === 1'b1 && first_press < 0) first_press = edge_no;
    if (repeating === 1'b1 && rep_edge < 0) rep_edge = edge_no;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw);
  endtask

  task automatic clear_log();
    step_q.delete();
    first_press = -1;
    rep_edge    = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_step_n", {31'd0, step_n}, 32'd1);
    chk("rst_pressed", {31'd0, pressed}, 32'd0);
    chk("rst_repeating", {31'd0, repeating}, 32'd0);
    chk("rst_lights", {24'd0, lights}, 32'h01);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  int e0;
  int r0;
  logic [7:0] exp_lights;

  initial begin
    reset     = 1'b1;
    btn_raw_n = 1'b1;
    edge_no   = 0;
    model_reset();
    clear_log();
    @(posedge clk);
    #1;
    chk("init_step_n", {31'd0, step_n}, 32'd1);
    chk("init_pressed", {31'd0, pressed}, 32'd0);
    chk("init_repeating", {31'd0, repeating}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 5);

    // Clean press, 12 edges held: single step, no repeat.
    clear_log();
    e0 = edge_no + 1;
    hold(1'b0, 12);
    hold(1'b1, 10);
    chk("t1_nsteps", step_q.size(), 1);
    if (step_q.size() > 0) chk("t1_step_edge", step_q[0] - e0, 6);
    chk("t1_press_edge", first_press - e0, 6);
    chk("t1_no_repeat", rep_edge, -1);

    // Long hold: first step, delayed first repeat, then periodic repeats.
    clear_log();
    e0 = edge_no + 1;
    hold(1'b0, 40);
    chk("t2_nsteps", step_q.size(), 9);
    if (step_q.size() >= 4) begin
      chk("t2_step0", step_q[0] - e0, 6);
      chk("t2_step1", step_q[1] - e0, 16);
      chk("t2_step2", step_q[2] - e0, 19);
      chk("t2_step3", step_q[3] - e0, 22);
    end
    chk("t2_rep_edge", rep_edge - e0, 16);
    hold(1'b1, 12);

    // Short glitches in idle never produce a step.
    clear_log();
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 3);
    end
    hold(1'b1, 6);
    chk("t3_nsteps", step_q.size(), 0);
    chk("t3_never_pressed", first_press, -1);

    // Release bounce returns to held; clean release drops pressed six edges after first raw high.
    clear_log();
    hold(1'b0, 12);
    hold(1'b1, 2);
    hold(1'b0, 6);
    chk("t4_pressed_after_bounce", {31'd0, pressed}, 32'd1);
    r0 = edge_no + 1;
    hold(1'b1, 5);
    chk("t4_pressed_r0p4", {31'd0, pressed}, 32'd1);
    cyc(1'b1);
    chk("t4_pressed_r0p5", {31'd0, pressed}, 32'd1);
    cyc(1'b1);
    chk("t4_pressed_r0p6", {31'd0, pressed}, 32'd0);
    chk("t4_nsteps", step_q.size(), 1);
    chk("t4_edge_check", edge_no - r0, 6);
    hold(1'b1, 6);

    // Reset mid-repeat with the button still held, then a fresh full debounce.
    clear_log();
    hold(1'b0, 20);
    chk("t5_repeating", {31'd0, repeating}, 32'd1);
    do_reset();
    clear_log();
    e0 = edge_no + 1;
    hold(1'b0, 10);
    chk("t5_nsteps", step_q.size(), 1);
    if (step_q.size() > 0) chk("t5_step_edge", step_q[0] - e0, 6);
    hold(1'b1, 12);

    // Random press/release/bounce patterns against the model.
    for (int i = 0; i < 60; i++) begin
      hold(1'b0, $urandom_range(1, 28));
      hold(1'b1, $urandom_range(1, 12));
    end
    hold(1'b1, 12);

    // Integration with the rotator: nine clean presses walk the single lit LED around and wrap.
    do_reset();
    clear_log();
    for (int k = 1; k <= 9; k++) begin
      hold(1'b0, 8);
      hold(1'b1, 8);
      exp_lights = 8'h01 << (k % 8);
      chk($sformatf("t6_lights_%0d", k), {24'd0, lights}, {24'd0, exp_lights});
    end
    chk("t6_nsteps", step_q.size(), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
